// File: rtl/mem_split_unit_pkg.sv
// Shared definitions for the MEM-stage access sequencer.
// Provides RISC-V load/store funct3 codes, the sequencer state type and
// small decode helpers for legality and natural alignment.
package mem_split_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SPLIT,
    S_DONE
  } state_t;

  // funct3 3, 6 and 7 encode no load/store width.
  function automatic logic f3_legal(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd1, 3'd2, 3'd4, 3'd5: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  // Bytes are always aligned; halves need addr[0]=0; words need addr[1:0]=0.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lsb);
    case (f3[1:0])
      2'd1:    return lsb[0];
      2'd2:    return lsb != 2'd0;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_split_unit_merge.sv
// load_byte_merge: combinational extension of a reassembled little-endian
// 4-byte accumulator according to the load funct3.
//   acc    in  32  bytes gathered by the split sequencer
//   func3  in  3   latched load funct3
//   result out 32  sign/zero-extended load result
module load_byte_merge
  import mem_split_unit_pkg::*;
(
  input  logic [31:0] acc,
  input  logic [2:0]  func3,
  output logic [31:0] result
);

  always_comb begin
    case (func3)
      F3_LB:   result = {{24{acc[7]}}, acc[7:0]};
      F3_LBU:  result = {24'd0, acc[7:0]};
      F3_LH:   result = {{16{acc[15]}}, acc[15:0]};
      F3_LHU:  result = {16'd0, acc[15:0]};
      default: result = acc;
    endcase
  end

endmodule

// File: rtl/mem_split_unit.sv
// mem_split_unit: MEM-stage access sequencer between EX/MEM and data memory.
// Aligned accesses pass straight through with zero latency; misaligned
// half/word accesses are split into byte accesses (sb / lbu) with the
// pipeline stalled, and split loads are reassembled and extended.
//   clk, rstn                          clock, async active-low reset
//   reqValid/reqWrite/reqFunc3/reqAddr/reqWriteData   request from EX/MEM
//   stall                              hold upstream stages
//   respValid/respData                 load result
//   misalignTrap                       misaligned access with SPLIT_EN=0
//   memWriteEnable/memFunc3/memAddr/memWriteData/memReadData   data memory
module mem_split_unit
  import mem_split_unit_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              reqValid,
  input  logic              reqWrite,
  input  logic [2:0]        reqFunc3,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [DATA_W-1:0] reqWriteData,
  output logic              stall,
  output logic              respValid,
  output logic [DATA_W-1:0] respData,
  output logic              misalignTrap,
  output logic              memWriteEnable,
  output logic [2:0]        memFunc3,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWriteData,
  input  logic [DATA_W-1:0] memReadData
);

  state_t            state;
  logic [1:0]        cnt;
  logic [31:0]       acc;
  logic [ADDR_W-1:0] base;
  logic [DATA_W-1:0] wdata;
  logic [2:0]        f3;
  logic              wr;

  logic        go;
  logic        mis;
  logic        start_split;
  logic [1:0]  last;
  logic [7:0]  rd_byte;
  logic [31:0] merged;

  assign go          = reqValid & f3_legal(reqFunc3);
  assign mis         = f3_misaligned(reqFunc3, reqAddr[1:0]);
  assign start_split = SPLIT_EN & (state == S_IDLE) & go & mis;
  assign last        = (f3[1:0] == 2'd1) ? 2'd1 : 2'd3;
  assign rd_byte     = memReadData[7:0];

  load_byte_merge u_merge (
    .acc    (acc),
    .func3  (f3),
    .result (merged)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      cnt   <= '0;
      acc   <= '0;
      base  <= '0;
      wdata <= '0;
      f3    <= '0;
      wr    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_split) begin
            // Byte 0 is issued in the request cycle itself, so the
            // sequencer resumes at byte 1.
            base  <= reqAddr;
            wdata <= reqWriteData;
            f3    <= reqFunc3;
            wr    <= reqWrite;
            cnt   <= 2'd1;
            acc   <= {24'd0, reqWrite ? 8'h00 : rd_byte};
            state <= S_SPLIT;
          end
        end
        S_SPLIT: begin
          if (!wr) acc[{cnt, 3'b000} +: 8] <= rd_byte;
          if (cnt == last) begin
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs are gated by rstn so every output reads 0 while reset is held,
  // including the request passthrough paths.
  always_comb begin
    stall          = 1'b0;
    respValid      = 1'b0;
    respData       = '0;
    misalignTrap   = 1'b0;
    memWriteEnable = 1'b0;
    memFunc3       = '0;
    memAddr        = '0;
    memWriteData   = '0;
    if (rstn) begin
      case (state)
        S_IDLE: begin
          memFunc3     = reqFunc3;
          memAddr      = reqAddr;
          memWriteData = reqWriteData;
          if (go && !mis) begin
            memWriteEnable = reqWrite;
            respValid      = !reqWrite;
            if (!reqWrite) respData = memReadData;
          end else if (go && mis) begin
            if (SPLIT_EN) begin
              stall          = 1'b1;
              memFunc3       = reqWrite ? F3_SB : F3_LBU;
              memWriteEnable = reqWrite;
              memWriteData   = DATA_W'(reqWriteData[7:0]);
            end else begin
              misalignTrap = 1'b1;
            end
          end
        end
        S_SPLIT: begin
          stall          = 1'b1;
          memAddr        = base + ADDR_W'(cnt);
          memFunc3       = wr ? F3_SB : F3_LBU;
          memWriteEnable = wr;
          memWriteData   = DATA_W'(wdata[{cnt, 3'b000} +: 8]);
        end
        S_DONE: begin
          respValid = !wr;
          if (!wr) respData = DATA_W'(merged);
        end
        default: ;
      endcase
    end
  end

endmodule
